// File: rtl/gate_pkg.sv
// Shared types and constants for the logic-gate self-test controller.
package gate_pkg;

  // Controller states; the encoding is visible on the debug state port.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_APPLY  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_CHECK  = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  // Bit positions of each gate inside the 6-bit result word.
  localparam int AND_B  = 0;
  localparam int OR_B   = 1;
  localparam int NAND_B = 2;
  localparam int NOR_B  = 3;
  localparam int XOR_B  = 4;
  localparam int XNOR_B = 5;
  localparam int NUM_GATES = 6;

  // Legal settle-cycle range and the counter width that covers it.
  localparam int SETTLE_MIN = 1;
  localparam int SETTLE_MAX = 15;
  localparam int CNT_W      = 4;

endpackage

// File: rtl/gate_expect.sv
// Golden truth table: expected gate-unit outputs for one 2-bit input vector.
module gate_expect
  import gate_pkg::*;
(
  input  logic [1:0]           vec_i,
  output logic [NUM_GATES-1:0] exp_o
);

  logic a;
  logic b;

  assign a = vec_i[1];
  assign b = vec_i[0];

  // Build the expected word bit by bit using the shared bit positions.
  always_comb begin
    exp_o         = '0;
    exp_o[AND_B]  = a & b;
    exp_o[OR_B]   = a | b;
    exp_o[NAND_B] = ~(a & b);
    exp_o[NOR_B]  = ~(a | b);
    exp_o[XOR_B]  = a ^ b;
    exp_o[XNOR_B] = ~(a ^ b);
  end

endmodule

// File: rtl/gate_selftest_ctrl.sv
// Self-test sequencer for an external 6-gate unit: walks the four input
// vectors, waits SETTLE cycles for each, compares the results against the
// truth table and accumulates per-vector and per-gate error masks.
// SETTLE must lie in SETTLE_MIN..SETTLE_MAX so it fits the 4-bit counter.
module gate_selftest_ctrl
  import gate_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  output logic                 a_o,
  output logic                 b_o,
  input  logic [NUM_GATES-1:0] res_i,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [3:0]           err_vec,
  output logic [NUM_GATES-1:0] err_gate,
  output logic [2:0]           state_o
);

  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE - 1);

  state_e               state_q;
  logic [1:0]           vec_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 a_q;
  logic                 b_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 pass_q;
  logic [3:0]           err_vec_q;
  logic [NUM_GATES-1:0] err_gate_q;

  logic [NUM_GATES-1:0] exp_res;
  logic [NUM_GATES-1:0] mismatch;
  logic [NUM_GATES-1:0] err_gate_d;
  logic [1:0]           vec_d;

  gate_expect u_expect (
    .vec_i (vec_q),
    .exp_o (exp_res)
  );

  assign mismatch   = res_i ^ exp_res;
  assign err_gate_d = err_gate_q | mismatch;
  assign vec_d      = vec_q + 2'd1;

  // Sequencer FSM. Handshake: start is a level sampled when the controller
  // can accept a run (IDLE, or the final DONE cycle so a held start gives
  // back-to-back runs); abort is a level that wins over every transition
  // outside IDLE; done is a one-cycle pulse aligned with updated pass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      vec_q      <= 2'd0;
      cnt_q      <= '0;
      a_q        <= 1'b0;
      b_q        <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_vec_q  <= '0;
      err_gate_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (abort && state_q != ST_IDLE) begin
        state_q    <= ST_IDLE;
        vec_q      <= 2'd0;
        cnt_q      <= '0;
        a_q        <= 1'b0;
        b_q        <= 1'b0;
        busy_q     <= 1'b0;
        err_vec_q  <= '0;
        err_gate_q <= '0;
      end else begin
        case (state_q)
          ST_IDLE, ST_DONE: begin
            if (start) begin
              state_q    <= ST_APPLY;
              vec_q      <= 2'd0;
              a_q        <= 1'b0;
              b_q        <= 1'b0;
              busy_q     <= 1'b1;
              err_vec_q  <= '0;
              err_gate_q <= '0;
            end else begin
              state_q <= ST_IDLE;
              a_q     <= 1'b0;
              b_q     <= 1'b0;
              busy_q  <= 1'b0;
            end
          end
          ST_APPLY: begin
            state_q <= ST_SETTLE;
            cnt_q   <= SETTLE_LOAD;
          end
          ST_SETTLE: begin
            if (cnt_q == '0) begin
              state_q <= ST_CHECK;
            end else begin
              cnt_q <= cnt_q - CNT_W'(1);
            end
          end
          ST_CHECK: begin
            err_gate_q <= err_gate_d;
            if (|mismatch) begin
              err_vec_q[vec_q] <= 1'b1;
            end
            if (vec_q == 2'd3) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
              pass_q  <= (err_gate_d == '0);
            end else begin
              state_q <= ST_APPLY;
              vec_q   <= vec_d;
              a_q     <= vec_d[1];
              b_q     <= vec_d[0];
            end
          end
          default: begin
            state_q <= ST_IDLE;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign a_o      = a_q;
  assign b_o      = b_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign err_vec  = err_vec_q;
  assign err_gate = err_gate_q;
  assign state_o  = state_q;

endmodule

// File: tb/tb_gate_selftest_ctrl.sv
// Bench for gate_selftest_ctrl: an external gate-unit model with injectable
// faults, a directed driver, and a scoreboard of {pass, err_vec, err_gate}
// plus the expected done cycle, checked by monitors on every done pulse.
module tb_gate_selftest_ctrl;
  import gate_pkg::*;

  localparam int W  = 11;
  localparam int S1 = 1;
  localparam int S4 = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT (SETTLE=1) ----------------
  logic       start, abort, a_o, b_o, busy, done, pass;
  logic [5:0] res, err_gate;
  logic [3:0] err_vec;
  logic [2:0] state;
  int         fault;

  gate_selftest_ctrl #(.SETTLE(S1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .a_o(a_o), .b_o(b_o), .res_i(res), .busy(busy), .done(done),
    .pass(pass), .err_vec(err_vec), .err_gate(err_gate), .state_o(state)
  );

  // ---------------- DUT (SETTLE=4) ----------------
  logic       start4, abort4, a4, b4, busy4, done4, pass4;
  logic [5:0] res4, err_gate4;
  logic [3:0] err_vec4;
  logic [2:0] state4;

  gate_selftest_ctrl #(.SETTLE(S4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .abort(abort4),
    .a_o(a4), .b_o(b4), .res_i(res4), .busy(busy4), .done(done4),
    .pass(pass4), .err_vec(err_vec4), .err_gate(err_gate4), .state_o(state4)
  );

  // External gate unit: mode 0 correct, 1 AND stuck-at-0, 2 XOR/XNOR swapped.
  function automatic logic [5:0] gate_unit(input logic a, input logic b, input int mode);
    logic [5:0] r;
    r[AND_B]  = a & b;
    r[OR_B]   = a | b;
    r[NAND_B] = ~(a & b);
    r[NOR_B]  = ~(a | b);
    r[XOR_B]  = a ^ b;
    r[XNOR_B] = ~(a ^ b);
    if (mode == 1) r[AND_B] = 1'b0;
    if (mode == 2) begin
      r[XOR_B]  = ~(a ^ b);
      r[XNOR_B] = a ^ b;
    end
    return r;
  endfunction

  assign res  = gate_unit(a_o, b_o, fault);
  assign res4 = gate_unit(a4, b4, 0);

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int           exp_cyc_q[$];
  logic [W-1:0] exp4_q[$];
  int           exp4_cyc_q[$];
  int checks = 0, failures = 0;
  int done_cnt = 0, done4_cnt = 0;
  int chk_idx = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: vector driven in each CHECK cycle, and result/latency on done.
  always @(negedge clk) begin
    logic [W-1:0] e;
    int           ec;
    if (rst_n && state == ST_CHECK) begin
      check("vec_drive", {30'd0, a_o, b_o}, {30'd0, chk_idx[1:0]});
      chk_idx++;
    end
    if (rst_n && done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        e  = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        check("result", {21'd0, pass, err_vec, err_gate}, {21'd0, e});
        check("done_cycle", cyc, ec);
      end
    end
  end

  // Monitor for the SETTLE=4 instance.
  always @(negedge clk) begin
    logic [W-1:0] e;
    int           ec;
    if (rst_n && done4) begin
      done4_cnt++;
      if (exp4_q.size() == 0) begin
        check("unexpected_done4", 32'd1, 32'd0);
      end else begin
        e  = exp4_q.pop_front();
        ec = exp4_cyc_q.pop_front();
        check("result4", {21'd0, pass4, err_vec4, err_gate4}, {21'd0, e});
        check("done4_cycle", cyc, ec);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue_start(input bit push, input logic [W-1:0] exp_res, input bit with_abort);
    @(negedge clk);
    start   = 1'b1;
    abort   = with_abort;
    chk_idx = 0;
    if (push) begin
      exp_q.push_back(exp_res);
      exp_cyc_q.push_back(cyc + 1 + 4 * (S1 + 2));
    end
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check("busy_after_start", {31'd0, busy}, 32'd1);
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_cnt < target && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("done_timeout", done_cnt, target);
  endtask

  task automatic wait_idle_checks();
    repeat (2) @(negedge clk);
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("idle_state", {29'd0, state}, {29'd0, ST_IDLE});
    check("idle_ab", {30'd0, a_o, b_o}, 32'd0);
  endtask

  task automatic wait_vec_settle(input logic [1:0] v);
    int n = 0;
    while (!(state == ST_SETTLE && {a_o, b_o} == v) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("settle_reached", {31'd0, state == ST_SETTLE && {a_o, b_o} == v}, 32'd1);
  endtask

  task automatic check_reset_state();
    check("rst_state", {29'd0, state}, {29'd0, ST_IDLE});
    check("rst_ab", {30'd0, a_o, b_o}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_pass", {31'd0, pass}, 32'd0);
    check("rst_err_vec", {28'd0, err_vec}, 32'd0);
    check("rst_err_gate", {26'd0, err_gate}, 32'd0);
  endtask

  // Watchdog so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    int n0;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; fault = 0;
    start4 = 1'b0; abort4 = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_state();
    rst_n = 1'b1;
    @(negedge clk);

    // Correct unit: pass, no errors, done 13 cycles after start.
    fault = 0;
    issue_start(1'b1, {1'b1, 4'b0000, 6'b000000}, 1'b0);
    wait_done(1);
    wait_idle_checks();

    // AND stuck-at-0: only vector 11 fails; extra start mid-run is ignored.
    fault = 1;
    issue_start(1'b1, {1'b0, 4'b1000, 6'b000001}, 1'b0);
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(2);
    wait_idle_checks();

    // XOR/XNOR swapped: every vector fails on both bits.
    fault = 2;
    issue_start(1'b1, {1'b0, 4'b1111, 6'b110000}, 1'b0);
    wait_done(3);
    wait_idle_checks();

    // Start and abort together in IDLE: start wins.
    fault = 0;
    issue_start(1'b1, {1'b1, 4'b0000, 6'b000000}, 1'b1);
    wait_done(4);
    wait_idle_checks();

    // Abort during vector 10 SETTLE with errors already accumulated.
    fault = 2;
    issue_start(1'b0, '0, 1'b0);
    wait_vec_settle(2'b10);
    abort = 1'b1;
    @(posedge clk);
    #1;
    check("abort_state", {29'd0, state}, {29'd0, ST_IDLE});
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_ab", {30'd0, a_o, b_o}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_pass_kept", {31'd0, pass}, 32'd1);
    check("abort_err_vec", {28'd0, err_vec}, 32'd0);
    check("abort_err_gate", {26'd0, err_gate}, 32'd0);
    @(negedge clk);
    abort = 1'b0;
    repeat (20) @(negedge clk);
    check("abort_no_done", done_cnt, 4);

    // Asynchronous reset during vector 01, then a clean run.
    issue_start(1'b0, '0, 1'b0);
    wait_vec_settle(2'b01);
    #1 rst_n = 1'b0;
    #1;
    check_reset_state();
    @(negedge clk);
    rst_n = 1'b1;
    fault = 0;
    repeat (2) @(negedge clk);
    issue_start(1'b1, {1'b1, 4'b0000, 6'b000000}, 1'b0);
    wait_done(5);
    wait_idle_checks();

    // SETTLE=4 with start held: back-to-back runs, done every 25 cycles.
    @(negedge clk);
    start4 = 1'b1;
    n0 = cyc + 1;
    for (int k = 0; k < 3; k++) begin
      exp4_q.push_back({1'b1, 4'b0000, 6'b000000});
      exp4_cyc_q.push_back(n0 + 4 * (S4 + 2) + 25 * k);
    end
    n = 0;
    while (done4_cnt < 2 && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    start4 = 1'b0;
    n = 0;
    while (done4_cnt < 3 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("done4_count", done4_cnt, 3);
    repeat (40) @(negedge clk);
    check("done4_stopped", done4_cnt, 3);
    check("busy4_idle", {31'd0, busy4}, 32'd0);

    check("exp_q_drained", exp_q.size(), 0);
    check("exp4_q_drained", exp4_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
